// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the batch multiplier sequencer: FSM state codes,
// multiplier latency, result stride and the saturation helper.
// Optional feature macro: MULT_SAT_EN (one saturated result byte per pair).
package mult_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_A  = 3'd1;
  localparam logic [2:0] ST_RD_B  = 3'd2;
  localparam logic [2:0] ST_MUL   = 3'd3;
  localparam logic [2:0] ST_WR_LO = 3'd4;
  localparam logic [2:0] ST_WR_HI = 3'd5;
  localparam logic [2:0] ST_NEXT  = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // Cycles from multiplier start to its valid pulse.
  localparam int MULT_LAT = 8;

  // Result bytes written per operand pair.
`ifdef MULT_SAT_EN
  localparam int RES_STRIDE = 1;
`else
  localparam int RES_STRIDE = 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RD_A  = ST_RD_A,
    S_RD_B  = ST_RD_B,
    S_MUL   = ST_MUL,
    S_WR_LO = ST_WR_LO,
    S_WR_HI = ST_WR_HI,
    S_NEXT  = ST_NEXT,
    S_DONE  = ST_DONE
  } state_t;

  // Clamp a 16-bit product into one byte.
  function automatic logic [7:0] sat8(input logic [15:0] p);
    return (p > 16'd255) ? 8'hFF : p[7:0];
  endfunction

endpackage

// File: rtl/shift_add_mult8.sv
// 8x8 unsigned shift-add multiplier. The first partial step is folded into
// the start cycle so valid pulses exactly MULT_LAT cycles after start.
// product holds its final value until the next start.
module shift_add_mult8
  import mult_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        valid,
  output logic [15:0] product
);

  localparam logic [2:0] LAST_STEP = 3'(MULT_LAT - 1);

  logic [7:0] mcand_r;
  logic [2:0] step_r;

  // One iteration: add multiplicand into the high half if multiplier LSB is set, shift right.
  function automatic logic [15:0] sa_step(input logic [15:0] p, input logic [7:0] m);
    logic [8:0] sum;
    sum = {1'b0, p[15:8]} + (p[0] ? {1'b0, m} : 9'd0);
    return {sum, p[7:1]};
  endfunction

  // Iteration register: load on start, then step until the last iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r <= 8'd0;
      step_r  <= 3'd0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      product <= 16'd0;
    end else if (start) begin
      mcand_r <= a;
      step_r  <= 3'd1;
      busy    <= 1'b1;
      valid   <= 1'b0;
      product <= sa_step({8'd0, b}, a);
    end else if (busy) begin
      product <= sa_step(product, mcand_r);
      step_r  <= step_r + 3'd1;
      busy    <= (step_r != LAST_STEP);
      valid   <= (step_r == LAST_STEP);
    end else begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_batch_ctrl.sv
// Batch sequencer: reads operand pairs from a sync-read single-port RAM,
// multiplies them and writes each product back, then pulses done.
// All outputs are registered from the next-state decode so they line up
// with the state shown on st_debug.
// Optional feature macro: MULT_SAT_EN (write one saturated byte per pair).
module mult_batch_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] op_base,
  input  logic [AW-1:0] res_base,
  input  logic [CW-1:0] count,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          busy,
  output logic          done,
  output logic [2:0]    st_debug
);

  localparam logic [AW-1:0] ADDR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] OP_STEP   = AW'(2'd2);
  localparam logic [AW-1:0] RES_STEP  = AW'(RES_STRIDE);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);

  state_t        state_r, state_s;
  logic [AW-1:0] op_ptr_r, op_ptr_s, res_ptr_r, res_ptr_s;
  logic [CW-1:0] idx_r, idx_s, count_r, count_s;
  logic [7:0]    a_r;
  logic          mul_first_r;
  logic          mult_start_s, mult_busy_s, mult_valid_s;
  logic [15:0]   product_s;
  logic [AW-1:0] ram_addr_s;
  logic          ram_we_s, busy_s, done_s;
  logic [7:0]    ram_wdata_s;

  assign mult_start_s = (state_r == S_MUL) && mul_first_r && !mult_busy_s;
  assign st_debug     = state_r;

  shift_add_mult8 u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mult_start_s),
    .a       (a_r),
    .b       (ram_rdata),
    .busy    (mult_busy_s),
    .valid   (mult_valid_s),
    .product (product_s)
  );

  // Next state plus pointer/index/count bookkeeping.
  always_comb begin
    state_s   = state_r;
    op_ptr_s  = op_ptr_r;
    res_ptr_s = res_ptr_r;
    idx_s     = idx_r;
    count_s   = count_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          op_ptr_s  = op_base;
          res_ptr_s = res_base;
          idx_s     = CNT_ZERO;
          count_s   = count;
          state_s   = (count != CNT_ZERO) ? S_RD_A : S_DONE;
        end else begin
          state_s   = S_IDLE;
        end
      end
      S_RD_A:  state_s = S_RD_B;
      S_RD_B:  state_s = S_MUL;
      S_MUL: begin
        if (mult_valid_s) begin
          state_s = S_WR_LO;
        end else begin
          state_s = S_MUL;
        end
      end
`ifdef MULT_SAT_EN
      S_WR_LO: state_s = S_NEXT;
`else
      S_WR_LO: state_s = S_WR_HI;
`endif
      S_WR_HI: state_s = S_NEXT;
      S_NEXT: begin
        op_ptr_s  = op_ptr_r + OP_STEP;
        res_ptr_s = res_ptr_r + RES_STEP;
        idx_s     = idx_r + CNT_ONE;
        state_s   = (idx_r == count_r - CNT_ONE) ? S_DONE : S_RD_A;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode for the upcoming state, using the upcoming pointer values.
  always_comb begin
    ram_addr_s  = {AW{1'b0}};
    ram_we_s    = 1'b0;
    ram_wdata_s = 8'd0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_s)
      S_RD_A: begin
        ram_addr_s = op_ptr_s;
        busy_s     = 1'b1;
      end
      S_RD_B: begin
        ram_addr_s = op_ptr_s + ADDR_ONE;
        busy_s     = 1'b1;
      end
      S_MUL:  busy_s = 1'b1;
      S_WR_LO: begin
        ram_we_s   = 1'b1;
        ram_addr_s = res_ptr_s;
`ifdef MULT_SAT_EN
        ram_wdata_s = sat8(product_s);
`else
        ram_wdata_s = product_s[7:0];
`endif
        busy_s     = 1'b1;
      end
      S_WR_HI: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = res_ptr_s + ADDR_ONE;
        ram_wdata_s = product_s[15:8];
        busy_s      = 1'b1;
      end
      S_NEXT: busy_s = 1'b1;
      S_DONE: done_s = 1'b1;
      default: begin
        ram_addr_s = {AW{1'b0}};
        busy_s     = 1'b0;
      end
    endcase
  end

  // State, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      op_ptr_r    <= {AW{1'b0}};
      res_ptr_r   <= {AW{1'b0}};
      idx_r       <= CNT_ZERO;
      count_r     <= CNT_ZERO;
      a_r         <= 8'd0;
      mul_first_r <= 1'b0;
      ram_addr    <= {AW{1'b0}};
      ram_we      <= 1'b0;
      ram_wdata   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_s;
      op_ptr_r    <= op_ptr_s;
      res_ptr_r   <= res_ptr_s;
      idx_r       <= idx_s;
      count_r     <= count_s;
      a_r         <= (state_r == S_RD_B) ? ram_rdata : a_r;
      mul_first_r <= (state_s == S_MUL) && (state_r != S_MUL);
      ram_addr    <= ram_addr_s;
      ram_we      <= ram_we_s;
      ram_wdata   <= ram_wdata_s;
      busy        <= busy_s;
      done        <= done_s;
    end
  end

endmodule

// File: tb/tb_mult_batch_ctrl.sv
// Self-checking bench for mult_batch_ctrl: a sync-read RAM model, a
// sequential reference model of the batch, and one task per scenario.
module tb_mult_batch_ctrl;

`ifdef MULT_SAT_EN
  localparam int PAIR_CYC    = 13;
  localparam int WE_PER_PAIR = 1;
`else
  localparam int PAIR_CYC    = 14;
  localparam int WE_PER_PAIR = 2;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] op_base, res_base, count;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we, busy, done;
  logic [2:0] st_debug;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int stray_we = 0;

  mult_batch_ctrl #(.AW(8), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op_base(op_base),
    .res_base(res_base), .count(count), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .done(done),
    .st_debug(st_debug)
  );

  always #5 clk = ~clk;

  // Single-port RAM with synchronous read; the bench preloads through ld_*.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
    ram_rdata <= mem[ram_addr];
  end

  // Event counters sampled on the pre-edge values of each cycle.
  always @(posedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (ram_we && !(st_debug == 3'd4 || st_debug == 3'd5)) stray_we <= stray_we + 1;
  end

  task automatic ram_load(input logic [7:0] ad, input logic [7:0] dt);
    ld_en = 1'b1; ld_addr = ad; ld_data = dt;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Reference: process pairs in order straight from the batch rules.
  task automatic model_batch(input logic [7:0] ob, input logic [7:0] rb, input int cnt);
    logic [7:0] op, rp, op1, rp1;
    logic [15:0] p;
    op = ob; rp = rb;
    for (int i = 0; i < cnt; i++) begin
      op1 = op + 8'd1;
      p = 16'(exp_mem[op]) * 16'(exp_mem[op1]);
`ifdef MULT_SAT_EN
      exp_mem[rp] = (p > 16'd255) ? 8'hFF : p[7:0];
      rp = rp + 8'd1;
`else
      exp_mem[rp] = p[7:0];
      rp1 = rp + 8'd1;
      exp_mem[rp1] = p[15:8];
      rp = rp + 8'd2;
`endif
      op = op + 8'd2;
    end
  endtask

  task automatic diff_mem(output int nb);
    nb = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) nb++;
  endtask

  task automatic snap_mem();
    for (int k = 0; k < 256; k++) exp_mem[k] = mem[k];
  endtask

  task automatic run_batch(input logic [7:0] ob, input logic [7:0] rb, input logic [7:0] cnt,
                           input bit inject, output int lat, output logic busy1,
                           output int nbad, output int dwe, output int ddone);
    int we0, d0, t, budget;
    snap_mem();
    model_batch(ob, rb, int'(cnt));
    @(negedge clk);
    we0 = we_cnt; d0 = done_cnt;
    op_base = ob; res_base = rb; count = cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_base = 8'($urandom); res_base = 8'($urandom); count = 8'($urandom);
    busy1 = busy;
    budget = PAIR_CYC * int'(cnt) + 20;
    t = 0;
    while (done !== 1'b1 && t < budget) begin
      start = inject && (t == 5);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    lat = t;
    repeat (3) @(negedge clk);
    dwe = we_cnt - we0;
    ddone = done_cnt - d0;
    diff_mem(nbad);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (st_debug !== 3'd0) begin n_bad++; $display("FAIL reset_st: got %0d want 0", st_debug); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ctl: busy=%b done=%b we=%b want 0", busy, done, ram_we); end
    n_cmp++; if (ram_addr !== 8'd0 || ram_wdata !== 8'd0) begin n_bad++; $display("FAIL reset_bus: addr=%h wdata=%h want 0", ram_addr, ram_wdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, nbad, dwe, dd; logic b1;
    ram_load(8'd0, 8'd3); ram_load(8'd1, 8'd5); ram_load(8'd8, 8'hAA); ram_load(8'd9, 8'hAA);
    run_batch(8'd0, 8'd8, 8'd1, 1'b0, lat, b1, nbad, dwe, dd);
    n_cmp++; if (mem[8] !== 8'h0F) begin n_bad++; $display("FAIL basic_lo: got %h want 0f", mem[8]); end
`ifndef MULT_SAT_EN
    n_cmp++; if (mem[9] !== 8'h00) begin n_bad++; $display("FAIL basic_hi: got %h want 00", mem[9]); end
`endif
    n_cmp++; if (lat !== PAIR_CYC) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, PAIR_CYC); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", b1); end
    n_cmp++; if (dwe !== WE_PER_PAIR || dd !== 1) begin n_bad++; $display("FAIL basic_counts: we=%0d done=%0d want %0d/1", dwe, dd, WE_PER_PAIR); end
  endtask

  task automatic test_spec_pairs();
    int lat, nbad, dwe, dd; logic b1;
    ram_load(8'd0, 8'd255); ram_load(8'd1, 8'd255); ram_load(8'd2, 8'd0); ram_load(8'd3, 8'd7);
    run_batch(8'd0, 8'd8, 8'd2, 1'b0, lat, b1, nbad, dwe, dd);
`ifdef MULT_SAT_EN
    n_cmp++; if (mem[8] !== 8'hFF || mem[9] !== 8'h00) begin n_bad++; $display("FAIL pairs_sat: got %h %h want ff 00", mem[8], mem[9]); end
`else
    n_cmp++; if (mem[8] !== 8'h01 || mem[9] !== 8'hFE) begin n_bad++; $display("FAIL pairs_p0: got %h %h want 01 fe", mem[8], mem[9]); end
    n_cmp++; if (mem[10] !== 8'h00 || mem[11] !== 8'h00) begin n_bad++; $display("FAIL pairs_p1: got %h %h want 00 00", mem[10], mem[11]); end
`endif
    n_cmp++; if (nbad !== 0) begin n_bad++; $display("FAIL pairs_mem: %0d bytes differ want 0", nbad); end
    n_cmp++; if (lat !== 2 * PAIR_CYC) begin n_bad++; $display("FAIL pairs_latency: got %0d want %0d", lat, 2 * PAIR_CYC); end
  endtask

  task automatic test_zero_count();
    int lat, nbad, dwe, dd; logic b1;
    run_batch(8'd20, 8'd40, 8'd0, 1'b0, lat, b1, nbad, dwe, dd);
    n_cmp++; if (lat !== 0 || dd !== 1) begin n_bad++; $display("FAIL zero_done: latency=%0d pulses=%0d want 0/1", lat, dd); end
    n_cmp++; if (dwe !== 0 || nbad !== 0) begin n_bad++; $display("FAIL zero_nowrite: we=%0d bytes=%0d want 0/0", dwe, nbad); end
  endtask

  task automatic test_start_while_busy();
    int lat, nbad, dwe, dd; logic b1;
    run_batch(8'd100, 8'd160, 8'd3, 1'b1, lat, b1, nbad, dwe, dd);
    n_cmp++; if (nbad !== 0) begin n_bad++; $display("FAIL busy_start_mem: %0d bytes differ want 0", nbad); end
    n_cmp++; if (dwe !== 3 * WE_PER_PAIR || dd !== 1) begin n_bad++; $display("FAIL busy_start_counts: we=%0d done=%0d want %0d/1", dwe, dd, 3 * WE_PER_PAIR); end
    n_cmp++; if (busy !== 1'b0 || st_debug !== 3'd0) begin n_bad++; $display("FAIL busy_start_idle: busy=%b st=%0d want 0/0", busy, st_debug); end
  endtask

  task automatic test_wrap();
    int lat, nbad, dwe, dd; logic b1;
    run_batch(8'hFE, 8'hFD, 8'd2, 1'b0, lat, b1, nbad, dwe, dd);
    n_cmp++; if (nbad !== 0) begin n_bad++; $display("FAIL wrap_mem: %0d bytes differ want 0", nbad); end
    n_cmp++; if (dwe !== 2 * WE_PER_PAIR) begin n_bad++; $display("FAIL wrap_we: got %0d want %0d", dwe, 2 * WE_PER_PAIR); end
  endtask

  task automatic test_random();
    int lat, nbad, dwe, dd; logic b1; logic [7:0] c;
    for (int i = 0; i < 6; i++) begin
      c = 8'($urandom_range(1, 6));
      run_batch(8'($urandom), 8'($urandom), c, 1'b0, lat, b1, nbad, dwe, dd);
      n_cmp++; if (nbad !== 0) begin n_bad++; $display("FAIL rand_mem[%0d]: %0d bytes differ want 0", i, nbad); end
      n_cmp++; if (lat !== PAIR_CYC * int'(c) || dd !== 1) begin n_bad++; $display("FAIL rand_done[%0d]: latency=%0d pulses=%0d want %0d/1", i, lat, dd, PAIR_CYC * int'(c)); end
    end
  endtask

  task automatic test_max_count();
    int lat, nbad, dwe, dd; logic b1;
    run_batch(8'($urandom), 8'($urandom), 8'd255, 1'b0, lat, b1, nbad, dwe, dd);
    n_cmp++; if (nbad !== 0) begin n_bad++; $display("FAIL max_mem: %0d bytes differ want 0", nbad); end
    n_cmp++; if (lat !== 255 * PAIR_CYC || dwe !== 255 * WE_PER_PAIR) begin n_bad++; $display("FAIL max_timing: latency=%0d we=%0d want %0d/%0d", lat, dwe, 255 * PAIR_CYC, 255 * WE_PER_PAIR); end
  endtask

  task automatic test_reset_mid_batch();
    int lat, nbad, dwe, dd, we0, d0, t, seen; logic b1;
    snap_mem();
    model_batch(8'd50, 8'd200, 1);
    @(negedge clk);
    we0 = we_cnt; d0 = done_cnt;
    op_base = 8'd50; res_base = 8'd200; count = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; t = 0;
    while (t < 200) begin
      if (st_debug === 3'd4) seen++;
      if (seen == 2) break;
      @(negedge clk);
      t++;
    end
    n_cmp++; if (seen !== 2) begin n_bad++; $display("FAIL midrst_reach: wr_lo visits=%0d want 2", seen); end
    reset = 1'b1;
    #1;
    n_cmp++; if (st_debug !== 3'd0 || ram_we !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_out: st=%0d we=%b busy=%b want 0/0/0", st_debug, ram_we, busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    diff_mem(nbad);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL midrst_nodone: pulses=%0d want 0", done_cnt - d0); end
    n_cmp++; if (we_cnt - we0 !== WE_PER_PAIR || nbad !== 0) begin n_bad++; $display("FAIL midrst_writes: we=%0d bytes=%0d want %0d/0", we_cnt - we0, nbad, WE_PER_PAIR); end
    ram_load(8'd70, 8'($urandom)); ram_load(8'd71, 8'($urandom));
    run_batch(8'd70, 8'd90, 8'd1, 1'b0, lat, b1, nbad, dwe, dd);
    n_cmp++; if (nbad !== 0 || lat !== PAIR_CYC || dd !== 1) begin n_bad++; $display("FAIL midrst_fresh: bytes=%0d latency=%0d pulses=%0d want 0/%0d/1", nbad, lat, dd, PAIR_CYC); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_base = 8'd0; res_base = 8'd0; count = 8'd0;
    ld_en = 1'b0; ld_addr = 8'd0; ld_data = 8'd0;
    test_reset();
    for (int k = 0; k < 256; k++) ram_load(8'(k), 8'($urandom));
    test_basic();
    test_spec_pairs();
    test_zero_count();
    test_start_while_busy();
    test_wrap();
    test_random();
    test_max_count();
    test_reset_mid_batch();
    n_cmp++; if (stray_we !== 0) begin n_bad++; $display("FAIL we_outside_wr: got %0d want 0", stray_we); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
